// File: rtl/proc_ctrl.sv
// proc_ctrl: time-step sequencer for the 16-bit simple processor.
// Latches IIIXXXYYY from DIN in T0, then drives one-hot register enables,
// bus selects and ALU controls across T1..T3. It pulses Done on the last step.
module proc_ctrl (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic [8:0]  IR,
  output logic [1:0]  Tstep,
  output logic        IRin,
  output logic [7:0]  Rin,
  output logic [7:0]  Rout,
  output logic        DINout,
  output logic        Gout,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  tstep_e     tstep_q, tstep_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       is_alu;

  // Only the low nine bits of DIN form an instruction. The upper bits are immediate data for the datapath.
  logic unused_din;
  assign unused_din = ^DIN[15:9];

  assign op     = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign is_alu = (op[2:1] == 2'b01);

  // Control decode per time step. Every output is gated off while reset is held.
  always_comb begin
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    DINout = 1'b0;
    Gout   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    unique case (tstep_q)
      T0: IRin = Run;
      T1: begin
        if (op == OP_MV) begin
          Rout[ry] = 1'b1;
          Rin[rx]  = 1'b1;
          Done     = 1'b1;
        end else if (op == OP_MVI) begin
          DINout  = 1'b1;
          Rin[rx] = 1'b1;
          Done    = 1'b1;
        end else if (is_alu) begin
          Rout[rx] = 1'b1;
          Ain      = 1'b1;
        end else begin
          Done = 1'b1;  // reserved opcodes retire as a NOP
        end
      end
      T2: begin
        if (is_alu) begin
          Rout[ry] = 1'b1;
          Gin      = 1'b1;
          AddSub   = op[0];
        end
      end
      T3: begin
        // Only add/sub get here. Done is unconditional so the counter can never wrap.
        Done = 1'b1;
        if (is_alu) begin
          Gout    = 1'b1;
          Rin[rx] = 1'b1;
        end
      end
      default: ;
    endcase
    if (!Resetn) begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      DINout = 1'b0;
      Gout   = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

  // Next step: T0 waits for Run, Done returns to T0, anything else advances.
  always_comb begin
    tstep_d = tstep_q;
    if (tstep_q == T0) tstep_d = Run ? T1 : T0;
    else if (Done)     tstep_d = T0;
    else               tstep_d = tstep_e'(tstep_q + 2'd1);
  end

  // The IR captures the instruction on the T0 edge that accepts Run.
  always_comb begin
    ir_d = ir_q;
    if (IRin) ir_d = DIN[8:0];
  end

  // Step counter and instruction register. Both clear asynchronously.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

  assign IR    = ir_q;
  assign Tstep = tstep_q;

endmodule

// File: doc/proc_ctrl.md
# proc_ctrl

Control unit for the 16-bit simple processor. It latches each instruction word presented on DIN while Run is high and sequences the register file, A/G registers, ALU and bus multiplexer through up to four time steps (T0–T3). It asserts Done on the final step of each instruction. It sits between the program memory, which supplies DIN, and the processor datapath, which it drives through one-hot enables and selects.

## Interface
- No parameters; instruction format fixed as IIIXXXYYY in DIN[8:0].
- Clock  in  1  single system clock, rising-edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request, sampled in T0.
- DIN  in  16  instruction word (T0) or immediate data (mvi, T1).
- IR  out  9  latched instruction.
- Tstep  out  2  current time step (0..3).
- IRin  out  1  IR load enable.
- Rin  out  8  one-hot register write enable, index = XXX.
- Rout  out  8  one-hot register-to-bus select.
- DINout  out  1  DIN-to-bus select.
- Gout  out  1  G-to-bus select.
- Ain  out  1  A register load.
- Gin  out  1  G register load.
- AddSub  out  1  ALU op: 0 = add, 1 = subtract.
- Done  out  1  final step of the current instruction.

## Operation
- State: 2-bit counter Tstep, plus the 9-bit IR register. Both are reset to 0 asynchronously on Resetn low.
- IR loads DIN[8:0] at the clock edge where IRin = 1.
- All control outputs are combinational from Tstep, IR and Run, and are forced to 0 while Resetn = 0.
- Outside the listed steps, every control output is 0. Exactly one bus source (Rout bit, DINout or Gout) may be active per step.
- Opcode III = IR[8:6], X = IR[5:3], Y = IR[2:0].
- T0 (all opcodes):
  - IRin = Run.
  - If Run = 1, go to T1; otherwise stay in T0.
- 000 mv Rx,Ry:
  - T1: Rout[Y] = 1, Rin[X] = 1, Done = 1.
- 001 mvi Rx,#D:
  - T1: DINout = 1, Rin[X] = 1, Done = 1.
  - DIN must carry D during T1.
- 010 add Rx,Ry and 011 sub Rx,Ry:
  - T1: Rout[X] = 1, Ain = 1.
  - T2: Rout[Y] = 1, Gin = 1, AddSub = III[0].
  - T3: Gout = 1, Rin[X] = 1, Done = 1.
- 1xx is reserved: treated as NOP.
  - T1: Done = 1, all enables 0.
- Any step with Done = 1: the next Tstep is T0.
  - Otherwise Tstep increments.
  - Tstep never wraps past 3; T3 always has Done = 1.
- Run is ignored outside T0. Dropping Run mid-instruction does not abort it.
- X = Y is legal. For example, add R3,R3 doubles R3; Rout and Rin both select bit 3 in their own steps.

## Timing
- Instruction latency from the T0 edge with Run = 1:
  - mv, mvi, NOP: 2 cycles.
  - add, sub: 4 cycles.
- Done is high for exactly one cycle per instruction.
- Back-to-back issue: the cycle after Done is T0. With Run held high, a new IR is loaded immediately, so there is no idle cycle beyond T0.
- Reset mid-instruction:
  - Tstep and IR clear immediately and asynchronously.
  - All outputs go to 0 (IR = 0, Tstep = 0) within the same cycle.
  - After Resetn rises, the block sits in T0 and waits for Run. The interrupted instruction is lost and not resumed.
- Reset values:
  - IR = 0, Tstep = 0.
  - IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done all 0.

## Test plan
- Reset during add T2, then release: IR = 0, Tstep = 0 and all outputs 0 immediately. The next Run = 1 with DIN = 0x040 (mvi R0) loads IR = 0x040.
- mvi R0,#10 then mvi R7,#20 (DIN = 0x040, 10, 0x078, 20, Run high):
  - Each takes 2 cycles.
  - T1 steps show DINout = 1 with Rin = 0x01, then Rin = 0x80.
  - Done pulses twice.
- add R0,R7 (DIN = 0x087):
  - T1: Rout = 0x01, Ain.
  - T2: Rout = 0x80, Gin, AddSub = 0.
  - T3: Gout, Rin = 0x01, Done.
  - Total 4 cycles.
- sub R0,R2 (DIN = 0x0C2): same sequence as add, with T2 AddSub = 1 and Rout = 0x04.
- mv R5,R5 (0x02D) and reserved 0x1FF:
  - mv: T1 Rout = 0x20, Rin = 0x20, Done.
  - Reserved: T1 Done only, no enables.
- Run = 0 for 5 cycles in T0: Tstep stays 0, IRin = 0, IR unchanged. Run pulsed low during add T2: the instruction still completes at T3.
